// File: rtl/tx_pause_frame_scheduler.sv
// IEEE 802.3x PAUSE frame scheduler: emits XOFF/XON frames (no CRC) as a
// 64-bit Avalon-ST stream, driven by an RX congestion level and a refresh timer.
module tx_pause_frame_scheduler #(
  parameter int unsigned REFRESH_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_enable,
  input  logic [47:0]              cfg_src_addr,
  input  logic [15:0]              cfg_pause_quanta,
  input  logic [REFRESH_WIDTH-1:0] cfg_refresh,
  input  logic                     xoff_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [2:0]               out_empty,
  output logic [1:0]               out_error,
  output logic                     paused,
  output logic [COUNT_WIDTH-1:0]   frames_sent
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t state, state_next;

  logic [2:0]               beat;
  logic                     xoff_req_q;
  logic                     xoff_pending;
  logic                     xon_pending;
  logic                     frame_xoff;
  logic [47:0]              sa_lat;
  logic [15:0]              quanta_lat;
  logic [REFRESH_WIDTH-1:0] refresh_cnt;

  logic req_rise;
  logic req_fall;
  logic launch;
  logic launch_xoff;
  logic beat_accept;
  logic last_accept;
  logic xoff_in_flight;
  logic refresh_run;
  logic refresh_fire;

  assign req_rise    = xoff_req & ~xoff_req_q;
  assign req_fall    = ~xoff_req & xoff_req_q;
  assign launch      = (state == IDLE) && cfg_enable && (xoff_pending || xon_pending);
  assign launch_xoff = xoff_pending;
  assign beat_accept = (state == SEND) && out_ready;
  assign last_accept = beat_accept && (beat == 3'd7);

  // An XOFF being launched on this very edge counts as in flight, so a
  // simultaneous fall still schedules the matching XON.
  assign xoff_in_flight = ((state != IDLE) && frame_xoff) || (launch && launch_xoff);

  assign refresh_run  = (state == IDLE) && paused && xoff_req && !xon_pending &&
                        (refresh_cnt != '0);
  assign refresh_fire = refresh_run && (refresh_cnt == REFRESH_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = SEND;
      SEND:    if (last_accept) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat       <= '0;
      frame_xoff <= 1'b0;
      sa_lat     <= '0;
      quanta_lat <= '0;
    end else begin
      if (launch) begin
        beat       <= '0;
        frame_xoff <= launch_xoff;
        sa_lat     <= cfg_src_addr;
        quanta_lat <= launch_xoff ? cfg_pause_quanta : 16'h0000;
      end else if (beat_accept) begin
        beat <= beat + 3'd1;
      end
    end
  end

  // Later assignments take precedence: edge events override the flag consumed
  // by a launch on the same edge, so at most one flag ends up set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xoff_req_q   <= 1'b0;
      xoff_pending <= 1'b0;
      xon_pending  <= 1'b0;
    end else begin
      xoff_req_q <= xoff_req;
      if (launch) begin
        if (launch_xoff) xoff_pending <= 1'b0;
        else             xon_pending  <= 1'b0;
      end
      if (req_rise) begin
        xoff_pending <= 1'b1;
        xon_pending  <= 1'b0;
      end
      if (req_fall) begin
        xoff_pending <= 1'b0;
        if (paused || xoff_in_flight) xon_pending <= 1'b1;
      end
      if (refresh_fire) xoff_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paused      <= 1'b0;
      frames_sent <= '0;
      refresh_cnt <= '0;
    end else begin
      if (state == DONE) begin
        frames_sent <= frames_sent + COUNT_WIDTH'(1);
        paused      <= frame_xoff;
        if (frame_xoff) refresh_cnt <= cfg_refresh;
      end else if (refresh_run) begin
        refresh_cnt <= refresh_cnt - REFRESH_WIDTH'(1);
      end
    end
  end

  always_comb begin
    out_valid         = (state == SEND);
    out_startofpacket = (state == SEND) && (beat == 3'd0);
    out_endofpacket   = (state == SEND) && (beat == 3'd7);
    out_empty         = out_endofpacket ? 3'd4 : 3'd0;
    out_error         = '0;
    out_data          = '0;
    if (state == SEND) begin
      case (beat)
        3'd0:    out_data = {48'h0180_C200_0001, sa_lat[47:32]};
        3'd1:    out_data = {sa_lat[31:0], 16'h8808, 16'h0001};
        3'd2:    out_data = {quanta_lat, 48'h0};
        default: out_data = '0;
      endcase
    end
  end

endmodule
